// File: rtl/sobel_window_gen.sv
`timescale 1ns/1ps
// Raster-order pixel stream to 3x3 neighbourhood generator feeding the sobel stage.
// Two line buffers plus a shifting window; the stream is stalled while a window awaits acknowledgement.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start_frame,
  input  logic [7:0]                    pixel_in,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  output logic [2:0][2:0][7:0]          comp_matrix,
  output logic                          sobel_en,
  input  logic                          sobel_done,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          frame_done
);

  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              last_pix;
  logic              accept;

  // line1 holds the previous row, line2 the row before that
  logic [7:0]        line1 [IMG_WIDTH];
  logic [7:0]        line2 [IMG_WIDTH];

  assign accept      = pixel_valid && (state == S_ACCEPT);
  assign pixel_ready = (state == S_ACCEPT);
  assign sobel_en    = (state == S_WAIT);
  assign frame_done  = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (start_frame) next_state = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (accept && (row >= ROW_TWO) && (col >= COL_TWO)) next_state = S_WAIT;
      end
      S_WAIT: begin
        if (sobel_done) next_state = last_pix ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Raster position of the next pixel; last_pix remembers whether the latest accept closed the frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row      <= '0;
      col      <= '0;
      last_pix <= 1'b0;
    end else if ((state == S_IDLE) && start_frame) begin
      row      <= '0;
      col      <= '0;
      last_pix <= 1'b0;
    end else if (accept) begin
      last_pix <= (row == ROW_LAST) && (col == COL_LAST);
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // NOTE: the line buffers are reset explicitly because reset must leave every buffer entry at zero;
  // a buffer that may power up unknown would instead drop the reset and save the clear logic.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line1       <= '{default: '0};
      line2       <= '{default: '0};
      comp_matrix <= '0;
      win_row     <= '0;
      win_col     <= '0;
    end else if (accept) begin
      line2[col] <= line1[col];
      line1[col] <= pixel_in;
      for (int r = 0; r < 3; r++) begin
        comp_matrix[r][0] <= comp_matrix[r][1];
        comp_matrix[r][1] <= comp_matrix[r][2];
      end
      // New rightmost column: two rows up, one row up, then the incoming pixel.
      comp_matrix[0][2] <= line2[col];
      comp_matrix[1][2] <= line1[col];
      comp_matrix[2][2] <= pixel_in;
      win_row <= row - ROW_W'(1);
      win_col <= col - COL_W'(1);
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
`timescale 1ns/1ps
// Directed bench for sobel_window_gen on a 4x4 frame: windows, stall, bubbles, reset and
// stray start_frame behaviour, with expected windows built from the bench's own pixel table.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic                 tb_clk = 1'b0;
  logic                 n_rst = 1'b0;
  logic                 start_frame = 1'b0;
  logic [7:0]           pixel_in = '0;
  logic                 pixel_valid = 1'b0;
  logic                 sobel_done = 1'b0;
  logic                 pixel_ready;
  logic [2:0][2:0][7:0] comp_matrix;
  logic                 sobel_en;
  logic [1:0]           win_row;
  logic [1:0]           win_col;
  logic                 frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]           pix_tab [W*H];
  logic [2:0][2:0][7:0] cap_mat [8];
  int                   cap_row [8];
  int                   cap_col [8];
  int                   cap_n = 0;
  int                   fd_n = 0;
  logic                 prev_en = 1'b0;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (tb_clk),
    .n_rst       (n_rst),
    .start_frame (start_frame),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .comp_matrix (comp_matrix),
    .sobel_en    (sobel_en),
    .sobel_done  (sobel_done),
    .win_row     (win_row),
    .win_col     (win_col),
    .frame_done  (frame_done)
  );

  always #5 tb_clk = ~tb_clk;

  // Record each sobel_en assertion once, on its rising edge, and count frame_done cycles.
  always @(negedge tb_clk) begin
    if (sobel_en && !prev_en && cap_n < 8) begin
      cap_mat[cap_n] = comp_matrix;
      cap_row[cap_n] = int'(win_row);
      cap_col[cap_n] = int'(win_col);
      cap_n++;
    end
    if (frame_done) fd_n++;
    prev_en = sobel_en;
  end

  // Window k of the frame: centre (R-1, C-1) where the completing pixel is (R, C).
  function automatic logic [2:0][2:0][7:0] exp_win(input int k);
    logic [2:0][2:0][7:0] e;
    int rr;
    int cc;
    rr = 2 + k / (W - 2);
    cc = 2 + k % (W - 2);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e[r][c] = pix_tab[(rr - 2 + r) * W + (cc - 2 + c)];
    return e;
  endfunction

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < W*H; i++) pix_tab[i] = 8'(i + 1);
  endtask

  task automatic start_pulse();
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] v, input bit gap, input bit sf);
    int budget;
    budget = 100;
    pixel_in    = v;
    pixel_valid = 1'b1;
    start_frame = sf;
    while (!pixel_ready && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (pixel_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout pixel=%0d pixel_ready=%b required 1", v, pixel_ready);
    end
    tick();
    pixel_valid = 1'b0;
    start_frame = 1'b0;
    if (gap) tick();
  endtask

  task automatic wait_frame_done(input string name);
    int budget;
    budget = 50;
    while (fd_n == 0 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (fd_n == 0) begin
      errors++;
      $display("FAIL %s_frame_done_timeout got %0d pulses required 1", name, fd_n);
    end
    tick();
    tick();
  endtask

  // Full ramp frame (pixels 1..16) with sobel_done tied high; optional bubbles and stray start_frame.
  task automatic run_ramp_frame(input string name, input bit gap, input int sf_at);
    fill_ramp();
    sobel_done = 1'b1;
    cap_n = 0;
    fd_n  = 0;
    start_pulse();
    for (int i = 0; i < W*H; i++) send_pixel(pix_tab[i], gap, i == sf_at);
    wait_frame_done(name);
    checks++;
    if (cap_n !== 4) begin
      errors++;
      $display("FAIL %s_win_count got %0d required 4", name, cap_n);
    end
    for (int k = 0; k < 4; k++) begin
      if (k < cap_n) begin
        checks++;
        if (cap_mat[k] !== exp_win(k)) begin
          errors++;
          $display("FAIL %s_win%0d_matrix got %h required %h", name, k, cap_mat[k], exp_win(k));
        end
        checks++;
        if (cap_row[k] !== 1 + k / 2 || cap_col[k] !== 1 + k % 2) begin
          errors++;
          $display("FAIL %s_win%0d_pos got (%0d,%0d) required (%0d,%0d)", name, k,
                   cap_row[k], cap_col[k], 1 + k / 2, 1 + k % 2);
        end
      end
    end
    if (cap_n >= 4) begin
      checks++;
      if (cap_mat[0][0][0] !== 8'd1 || cap_mat[0][1][1] !== 8'd6 || cap_mat[0][2][2] !== 8'd11) begin
        errors++;
        $display("FAIL %s_first_literal got %0d/%0d/%0d required 1/6/11", name,
                 cap_mat[0][0][0], cap_mat[0][1][1], cap_mat[0][2][2]);
      end
      checks++;
      if (cap_mat[3][0][0] !== 8'd6 || cap_mat[3][1][1] !== 8'd11 || cap_mat[3][2][2] !== 8'd16) begin
        errors++;
        $display("FAIL %s_last_literal got %0d/%0d/%0d required 6/11/16", name,
                 cap_mat[3][0][0], cap_mat[3][1][1], cap_mat[3][2][2]);
      end
    end
    checks++;
    if (fd_n !== 1) begin
      errors++;
      $display("FAIL %s_frame_done_pulses got %0d required 1", name, fd_n);
    end
    checks++;
    if (pixel_ready !== 1'b0 || sobel_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after got ready=%b en=%b required 0 0", name, pixel_ready, sobel_en);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #2;
    checks++;
    if (pixel_ready !== 1'b0 || sobel_en !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b en=%b done=%b required 0 0 0",
               pixel_ready, sobel_en, frame_done);
    end
    checks++;
    if (comp_matrix !== '0) begin
      errors++;
      $display("FAIL reset_matrix got %h required 0", comp_matrix);
    end
    checks++;
    if (win_row !== 2'd0 || win_col !== 2'd0) begin
      errors++;
      $display("FAIL reset_pos got (%0d,%0d) required (0,0)", win_row, win_col);
    end
    tick();
    n_rst = 1'b1;
    tick();
    checks++;
    if (pixel_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_ready got %b required 0", pixel_ready);
    end
  endtask

  task automatic test_basic_frame();
    run_ramp_frame("basic", 1'b0, -1);
  endtask

  task automatic test_stall();
    logic [2:0][2:0][7:0] w0;
    fill_ramp();
    w0 = exp_win(0);
    sobel_done = 1'b0;
    cap_n = 0;
    fd_n  = 0;
    start_pulse();
    for (int i = 0; i < 11; i++) send_pixel(pix_tab[i], 1'b0, 1'b0);
    checks++;
    if (sobel_en !== 1'b1 || comp_matrix !== w0) begin
      errors++;
      $display("FAIL stall_first got en=%b mat=%h required 1 %h", sobel_en, comp_matrix, w0);
    end
    pixel_in    = 8'd12;
    pixel_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (sobel_en !== 1'b1 || pixel_ready !== 1'b0 || comp_matrix !== w0) begin
        errors++;
        $display("FAIL stall_hold%0d got en=%b ready=%b mat=%h required 1 0 %h",
                 i, sobel_en, pixel_ready, comp_matrix, w0);
      end
    end
    sobel_done = 1'b1;
    tick();
    checks++;
    if (sobel_en !== 1'b0 || pixel_ready !== 1'b1 || comp_matrix[2][2] !== 8'd11) begin
      errors++;
      $display("FAIL stall_release got en=%b ready=%b newest=%0d required 0 1 11",
               sobel_en, pixel_ready, comp_matrix[2][2]);
    end
    for (int i = 11; i < W*H; i++) send_pixel(pix_tab[i], 1'b0, 1'b0);
    wait_frame_done("stall");
    checks++;
    if (cap_n !== 4) begin
      errors++;
      $display("FAIL stall_win_count got %0d required 4", cap_n);
    end
    if (cap_n >= 2) begin
      checks++;
      if (cap_mat[1] !== exp_win(1)) begin
        errors++;
        $display("FAIL stall_win1_matrix got %h required %h", cap_mat[1], exp_win(1));
      end
    end
  endtask

  task automatic test_bubbles();
    run_ramp_frame("bubbles", 1'b1, -1);
  endtask

  task automatic test_all_ff();
    logic [2:0][2:0][7:0] ff_all;
    ff_all = '1;
    for (int i = 0; i < W*H; i++) pix_tab[i] = ((i / W) <= 2 && (i % W) <= 2) ? 8'hFF : 8'h00;
    sobel_done = 1'b1;
    cap_n = 0;
    fd_n  = 0;
    start_pulse();
    for (int i = 0; i < W*H; i++) send_pixel(pix_tab[i], 1'b0, 1'b0);
    wait_frame_done("all_ff");
    checks++;
    if (cap_n !== 4) begin
      errors++;
      $display("FAIL all_ff_win_count got %0d required 4", cap_n);
    end
    if (cap_n >= 4) begin
      checks++;
      if (cap_mat[0] !== ff_all) begin
        errors++;
        $display("FAIL all_ff_first got %h required %h", cap_mat[0], ff_all);
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (cap_mat[k] !== exp_win(k)) begin
          errors++;
          $display("FAIL all_ff_win%0d got %h required %h", k, cap_mat[k], exp_win(k));
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    fill_ramp();
    sobel_done = 1'b0;
    cap_n = 0;
    fd_n  = 0;
    start_pulse();
    for (int i = 0; i < 11; i++) send_pixel(pix_tab[i], 1'b0, 1'b0);
    checks++;
    if (sobel_en !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_pre got en=%b required 1", sobel_en);
    end
    #1;
    n_rst = 1'b0;
    #1;
    checks++;
    if (sobel_en !== 1'b0 || pixel_ready !== 1'b0 || comp_matrix !== '0) begin
      errors++;
      $display("FAIL rstwait_async got en=%b ready=%b mat=%h required 0 0 0",
               sobel_en, pixel_ready, comp_matrix);
    end
    #1;
    n_rst = 1'b1;
    pixel_in    = 8'd12;
    pixel_valid = 1'b1;
    sobel_done  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pixel_ready !== 1'b0 || sobel_en !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL rstwait_idle%0d got ready=%b en=%b done=%b required 0 0 0",
                 i, pixel_ready, sobel_en, frame_done);
      end
    end
    pixel_valid = 1'b0;
    checks++;
    if (fd_n !== 0) begin
      errors++;
      $display("FAIL rstwait_no_frame_done got %0d required 0", fd_n);
    end
    run_ramp_frame("after_rst", 1'b0, -1);
  endtask

  task automatic test_start_mid_frame();
    run_ramp_frame("start_mid", 1'b0, 5);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_bubbles();
    test_all_ff();
    test_reset_in_wait();
    test_start_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
